spi_ram_ctrl: RTL and testbench

//  Memory-bus to serial SRAM bridge (23LC1024-class, SPI mode 0, sequential mode) for the femto SoC.

---
 rtl/femto_ram_pkg.sv | 41 ++++
 rtl/spi_shift_engine.sv | 91 +++++++++
 rtl/spi_ram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_ram_pkg.sv
// -----------------------------------------------------------------------------
// femto_ram_pkg
//   Shared constants and helpers for the femto SoC serial-SRAM bridge.
//   - CMD_READ / CMD_WRITE : 23LC1024 sequential-mode opcodes
//   - ram_state_e          : bridge sequencing states
//   - lowest_set()         : index of the lowest set bit of a byte mask
//   - byte_swap()          : reverse byte order of a 32-bit word
// -----------------------------------------------------------------------------
package femto_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Shifter width and bit-counter width shared by top and shift engine.
    localparam int SHIFT_W = 64;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } ram_state_e;

    // Index of the lowest set bit; returns 0 for an all-zero mask.
    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // The SRAM streams bytes in ascending address order, MSB-first on the
    // wire; the core wants the byte at addr+0 in [7:0].
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//   SPI mode-0 frame engine: one 64-bit shift register used for both TX and RX,
//   a down-counting bit counter, and SCK / CS_n generation at clk/2.
//
//   Ports
//     clk, resetn   system clock, synchronous active-low reset
//     start_i       load tx_i/len_i and begin a frame (engine must be idle)
//     len_i         frame length in bits minus one
//     tx_i          frame data, left aligned (bit 63 goes out first)
//     miso_i        serial data from the RAM
//     done_o        high in the final cycle of a frame (last SCK-high cycle)
//     rx_word_o     last 32 bits shifted in from MISO
//     cs_n_o        chip select, active low
//     sck_o         serial clock, idle low
//     mosi_o        serial data to the RAM
//
//   Each bit occupies an SCK-low cycle followed by an SCK-high cycle. MISO is
//   captured on the clk edge that raises SCK; MOSI advances on the clk edge
//   that lowers SCK. The frame ends on the edge that would have lowered SCK
//   after the last bit, so SCK and CS_n move together to their idle levels.
// -----------------------------------------------------------------------------
module spi_shift_engine
    import femto_ram_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   len_i,
    input  logic [SHIFT_W-1:0] tx_i,
    input  logic               miso_i,
    output logic               done_o,
    output logic [31:0]        rx_word_o,
    output logic               cs_n_o,
    output logic               sck_o,
    output logic               mosi_o
);

    logic               active_q;
    logic               cs_n_q;
    logic               sck_q;
    logic               mosi_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shreg_q;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the values from before the edge, regardless of order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cnt_q    <= '0;
            // NOTE: the shifter is a plain datapath register; resetting it is
            // cheap here and keeps rx_word_o deterministic after reset.
            shreg_q  <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cs_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= tx_i[SHIFT_W-1];
            cnt_q    <= len_i;
            shreg_q  <= tx_i;
        end else if (active_q) begin
            if (!sck_q) begin
                // Rising SCK: RAM latches MOSI, we capture MISO. Shifting left
                // also exposes the next TX bit at the top of the register.
                sck_q   <= 1'b1;
                shreg_q <= {shreg_q[SHIFT_W-2:0], miso_i};
            end else if (cnt_q == '0) begin
                // Last bit done: return SCK, CS_n and MOSI to idle together.
                active_q <= 1'b0;
                cs_n_q   <= 1'b1;
                sck_q    <= 1'b0;
                mosi_q   <= 1'b0;
            end else begin
                sck_q  <= 1'b0;
                cnt_q  <= cnt_q - 1'b1;
                mosi_q <= shreg_q[SHIFT_W-1];
            end
        end
    end

    assign done_o    = active_q && sck_q && (cnt_q == '0);
    assign rx_word_o = shreg_q[31:0];
    assign cs_n_o    = cs_n_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//   Bridges the femto core RAM port to a 23LC1024-class serial SRAM
//   (SPI mode 0, sequential mode). Word reads become one READ frame with four
//   data bytes; a full-mask write becomes one WRITE frame with four data bytes;
//   a partial-mask write becomes one single-byte WRITE frame per enabled byte,
//   lowest byte first. Every frame is followed by one CS_n-high GAP cycle.
//
//   Ports
//     clk, resetn    system clock, synchronous active-low reset
//     mem_addr       byte address (bits [1:0] ignored)
//     mem_wdata      write data, byte 0 in [7:0]
//     mem_wmask      byte enables; nonzero for one cycle requests a write
//     mem_rstrb      one-cycle read request (dropped if a write is requested)
//     mem_rdata      last read word, byte at addr+0 in [7:0]
//     mem_rbusy      read in progress
//     mem_wbusy      write in progress
//     spi_cs_n_ram   SRAM chip select, active low
//     spi_clk_ram    SRAM serial clock
//     spi_mosi_ram   serial data to SRAM
//     spi_miso_ram   serial data from SRAM
//
//   ADDR_W must not exceed 24 so that command + address + 32 data bits fit
//   in the 64-bit shifter.
// -----------------------------------------------------------------------------
module spi_ram_ctrl
    import femto_ram_pkg::ram_state_e;
    import femto_ram_pkg::ST_IDLE;
    import femto_ram_pkg::ST_LOAD;
    import femto_ram_pkg::ST_SHIFT;
    import femto_ram_pkg::ST_GAP;
    import femto_ram_pkg::SHIFT_W;
    import femto_ram_pkg::CNT_W;
    import femto_ram_pkg::lowest_set;
    import femto_ram_pkg::byte_swap;
#(
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] CMD_READ  = femto_ram_pkg::CMD_READ,
    parameter logic [7:0] CMD_WRITE = femto_ram_pkg::CMD_WRITE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wmask,
    input  logic              mem_rstrb,
    output logic [31:0]       mem_rdata,
    output logic              mem_rbusy,
    output logic              mem_wbusy,
    output logic              spi_cs_n_ram,
    output logic              spi_clk_ram,
    output logic              spi_mosi_ram,
    input  logic              spi_miso_ram
);

    localparam int             HDR_BITS = 8 + ADDR_W;
    localparam logic [CNT_W-1:0] LEN_WORD = CNT_W'(HDR_BITS + 32 - 1);
    localparam logic [CNT_W-1:0] LEN_BYTE = CNT_W'(HDR_BITS + 8 - 1);

    // Left-align command, address and data in the shifter.
    function automatic logic [SHIFT_W-1:0] frame(input logic [7:0]        cmd,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [31:0]       data);
        return (SHIFT_W'(cmd)  << (SHIFT_W - 8))
             | (SHIFT_W'(addr) << (SHIFT_W - HDR_BITS))
             | (SHIFT_W'(data) << (SHIFT_W - HDR_BITS - 32));
    endfunction

    ram_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;     // word-aligned request address
    logic [31:0]       wdata_q;
    logic [3:0]        pend_q;     // byte lanes still to write (partial masks)
    logic              rbusy_q;
    logic              wbusy_q;
    logic [31:0]       rdata_q;

    logic               req_wr;
    logic               req_rd;
    logic               can_accept;
    logic [1:0]         new_idx;
    logic [1:0]         next_idx;
    logic [ADDR_W-1:0]  addr_aligned;
    logic               start_new_d;
    logic               start_next_d;
    logic               start_d;
    logic [CNT_W-1:0]   len_d;
    logic [SHIFT_W-1:0] tx_d;

    logic               eng_done;
    logic [31:0]        eng_rx_word;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        start_new_d  = 1'b0;
        start_next_d = 1'b0;
        len_d        = '0;
        tx_d         = '0;

        req_wr       = |mem_wmask;
        req_rd       = mem_rstrb && !req_wr;
        new_idx      = lowest_set(mem_wmask);
        next_idx     = lowest_set(pend_q);
        addr_aligned = mem_addr & ~ADDR_W'(3);

        // Busy is already low in the final GAP cycle, so a new request may
        // legitimately arrive there as well as in IDLE.
        can_accept   = (state_q == ST_IDLE) || (state_q == ST_GAP && pend_q == 4'h0);

        if (state_q == ST_GAP && pend_q != 4'h0) begin
            start_next_d = 1'b1;
            len_d        = LEN_BYTE;
            tx_d         = frame(CMD_WRITE, addr_q | ADDR_W'(next_idx),
                                 {wdata_q[{next_idx, 3'b000} +: 8], 24'h0});
        end else if (can_accept && req_wr) begin
            start_new_d = 1'b1;
            if (mem_wmask == 4'hF) begin
                len_d = LEN_WORD;
                tx_d  = frame(CMD_WRITE, addr_aligned, byte_swap(mem_wdata));
            end else begin
                len_d = LEN_BYTE;
                tx_d  = frame(CMD_WRITE, addr_aligned | ADDR_W'(new_idx),
                              {mem_wdata[{new_idx, 3'b000} +: 8], 24'h0});
            end
        end else if (can_accept && req_rd) begin
            start_new_d = 1'b1;
            len_d       = LEN_WORD;
            tx_d        = frame(CMD_READ, addr_aligned, 32'h0);
        end

        start_d = start_new_d || start_next_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (start_next_d) begin
                        pend_q  <= pend_q & ~(4'b0001 << next_idx);
                        state_q <= ST_LOAD;
                    end else if (start_new_d) begin
                        addr_q  <= addr_aligned;
                        wdata_q <= mem_wdata;
                        // A full mask goes out as one frame; otherwise the
                        // first lane is in flight and the rest are pending.
                        pend_q  <= (mem_wmask == 4'hF) ? 4'h0
                                                       : (mem_wmask & ~(4'b0001 << new_idx));
                        wbusy_q <= req_wr;
                        rbusy_q <= !req_wr;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (eng_done) begin
                        state_q <= ST_GAP;
                        if (pend_q == 4'h0) begin
                            rbusy_q <= 1'b0;
                            wbusy_q <= 1'b0;
                            if (rbusy_q) rdata_q <= byte_swap(eng_rx_word);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    spi_shift_engine u_engine (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_d),
        .len_i     (len_d),
        .tx_i      (tx_d),
        .miso_i    (spi_miso_ram),
        .done_o    (eng_done),
        .rx_word_o (eng_rx_word),
        .cs_n_o    (spi_cs_n_ram),
        .sck_o     (spi_clk_ram),
        .mosi_o    (spi_mosi_ram)
    );

    assign mem_rdata = rdata_q;
    assign mem_rbusy = rbusy_q;
    assign mem_wbusy = wbusy_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_ctrl
//   Directed bench for spi_ram_ctrl. A behavioural 23LC1024 model collects the
//   MOSI bytes of every frame and returns rd_word MSB-first on MISO during the
//   data phase of a frame (one bit per SCK falling edge after the 32-bit
//   command+address header).
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        spi_cs_n_ram;
    logic        spi_clk_ram;
    logic        spi_mosi_ram;
    logic        spi_miso_ram = 1'b0;

    spi_ram_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rstrb    (mem_rstrb),
        .mem_rdata    (mem_rdata),
        .mem_rbusy    (mem_rbusy),
        .mem_wbusy    (mem_wbusy),
        .spi_cs_n_ram (spi_cs_n_ram),
        .spi_clk_ram  (spi_clk_ram),
        .spi_mosi_ram (spi_mosi_ram),
        .spi_miso_ram (spi_miso_ram)
    );

    always #5 clk = ~clk;

    // ---------------- serial SRAM model ----------------
    logic [31:0] rd_word = 32'h0;
    logic [7:0]  mbytes[$];
    int          fbits[$];
    int          frames = 0;
    int          sck_rises = 0;
    int          bit_cnt = 0;
    int          hi_run = 0;
    int          last_gap = 0;
    int          viol = 0;
    logic [7:0]  cur = 8'h0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    logic [4:0]  bi;

    always @(posedge clk) begin
        #1;
        if (prev_cs && !spi_cs_n_ram) begin
            bit_cnt  = 0;
            last_gap = hi_run;
        end
        if (!spi_cs_n_ram && !prev_sck && spi_clk_ram) begin
            cur = {cur[6:0], spi_mosi_ram};
            bit_cnt++;
            sck_rises++;
            if (bit_cnt % 8 == 0) mbytes.push_back(cur);
        end
        if (!spi_cs_n_ram && prev_sck && !spi_clk_ram) begin
            if (bit_cnt >= 32 && bit_cnt < 64) begin
                bi = 5'(63 - bit_cnt);
                spi_miso_ram = rd_word[bi];
            end else begin
                spi_miso_ram = 1'b0;
            end
        end
        if (!prev_cs && spi_cs_n_ram) begin
            frames++;
            fbits.push_back(bit_cnt);
            spi_miso_ram = 1'b0;
        end
        if (spi_cs_n_ram) begin
            hi_run++;
            if (spi_mosi_ram) viol++;
        end else begin
            hi_run = 0;
        end
        if ((spi_cs_n_ram != prev_cs) && spi_clk_ram) viol++;
        prev_cs  = spi_cs_n_ram;
        prev_sck = spi_clk_ram;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word4(input int i);
        return {mbytes[i], mbytes[i+1], mbytes[i+2], mbytes[i+3]};
    endfunction

    // Drive a request for one cycle (cycle T); returns at the negedge of T+1.
    task automatic send_req(input logic [23:0] a, input logic [31:0] d,
                            input logic [3:0] m, input logic rs);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = rs;
        @(negedge clk);
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
    endtask

    // Observe cycles T+1, T+2, ... (bounded); optionally fire a request
    // in cycle T+bump_at while the bridge should be busy.
    int w_fall, w_cs_last, w_rb1, w_wb1, w_rb_seen;

    task automatic watch(input int bump_at);
        w_fall = 0; w_cs_last = 0; w_rb1 = 0; w_wb1 = 0; w_rb_seen = 0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 1) begin
                w_rb1 = int'(mem_rbusy);
                w_wb1 = int'(mem_wbusy);
            end
            if (mem_rbusy) w_rb_seen = 1;
            if (!spi_cs_n_ram) w_cs_last = k;
            if (w_fall == 0 && !mem_rbusy && !mem_wbusy) w_fall = k;
            if (k == bump_at) begin
                mem_rstrb = 1'b1;
                mem_wmask = 4'hF;
                mem_addr  = 24'h000300;
            end else begin
                mem_rstrb = 1'b0;
                mem_wmask = 4'h0;
            end
            if (w_fall != 0 && k >= w_fall + 20) break;
            @(negedge clk);
        end
    endtask

    int b0, f0, r0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n",  32'(spi_cs_n_ram), 32'h1);
        check("rst_sck",   32'(spi_clk_ram),  32'h0);
        check("rst_mosi",  32'(spi_mosi_ram), 32'h0);
        check("rst_rbusy", 32'(mem_rbusy),    32'h0);
        check("rst_wbusy", 32'(mem_wbusy),    32'h0);
        check("rst_rdata", mem_rdata,         32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Word read at 0x000104, RAM returns 11 22 33 44
        rd_word = 32'h11223344;
        b0 = mbytes.size(); f0 = frames; r0 = sck_rises;
        send_req(24'h000104, 32'h0, 4'h0, 1'b1);
        watch(0);
        check("rd_rbusy_t1",  32'(w_rb1),               32'h1);
        check("rd_rbusy_fall",32'(w_fall),              32'd129);
        check("rd_cs_last",   32'(w_cs_last),           32'd128);
        check("rd_sck_rises", 32'(sck_rises - r0),      32'd64);
        check("rd_hdr",       word4(b0),                32'h03000104);
        check("rd_rdata",     mem_rdata,                32'h44332211);
        check("rd_frames",    32'(frames - f0),         32'd1);
        check("rd_bits",      32'(fbits[f0]),           32'd64);

        // Full-word write
        b0 = mbytes.size(); f0 = frames;
        send_req(24'h000020, 32'hDEADBEEF, 4'hF, 1'b0);
        watch(0);
        check("wr4_wbusy_t1", 32'(w_wb1),        32'h1);
        check("wr4_fall",     32'(w_fall),       32'd129);
        check("wr4_hdr",      word4(b0),         32'h02000020);
        check("wr4_data",     word4(b0 + 4),     32'hEFBEADDE);
        check("wr4_frames",   32'(frames - f0),  32'd1);
        check("wr4_no_rbusy", 32'(w_rb_seen),    32'h0);
        check("rdata_held",   mem_rdata,         32'h44332211);

        // Partial write, mask 0101 -> bytes 0 and 2
        b0 = mbytes.size(); f0 = frames;
        send_req(24'h000040, 32'hAABBCCDD, 4'b0101, 1'b0);
        watch(0);
        check("wrp_frames",  32'(frames - f0),   32'd2);
        check("wrp_hdr0",    word4(b0),          32'h02000040);
        check("wrp_dat0",    32'(mbytes[b0+4]),  32'h000000DD);
        check("wrp_hdr1",    word4(b0 + 5),      32'h02000042);
        check("wrp_dat1",    32'(mbytes[b0+9]),  32'h000000BB);
        check("wrp_gap",     32'(last_gap),      32'd1);
        check("wrp_bits0",   32'(fbits[f0]),     32'd40);
        check("wrp_fall",    32'(w_fall),        32'd162);

        // Same-cycle read strobe and write mask 0010: write wins
        b0 = mbytes.size(); f0 = frames;
        send_req(24'h000100, 32'h00005500, 4'b0010, 1'b1);
        watch(0);
        check("rw_frames",   32'(frames - f0),   32'd1);
        check("rw_hdr",      word4(b0),          32'h02000101);
        check("rw_dat",      32'(mbytes[b0+4]),  32'h00000055);
        check("rw_no_rbusy", 32'(w_rb_seen),     32'h0);
        check("rw_fall",     32'(w_fall),        32'd81);

        // Requests while busy are ignored
        rd_word = 32'hA1B2C3D4;
        b0 = mbytes.size(); f0 = frames;
        send_req(24'h000008, 32'h0, 4'h0, 1'b1);
        watch(10);
        check("bz_frames",   32'(frames - f0),   32'd1);
        check("bz_hdr",      word4(b0),          32'h03000008);
        check("bz_rdata",    mem_rdata,          32'hD4C3B2A1);

        // Reset held 3 cycles in the middle of a read
        send_req(24'h000200, 32'h0, 4'h0, 1'b1);
        repeat (29) @(negedge clk);
        check("mid_cs_low",  32'(spi_cs_n_ram),  32'h0);
        resetn = 1'b0;
        @(negedge clk);
        check("mr_cs_n",     32'(spi_cs_n_ram),  32'h1);
        check("mr_sck",      32'(spi_clk_ram),   32'h0);
        check("mr_rbusy",    32'(mem_rbusy),     32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("mr_rdata",    mem_rdata,          32'h0);
        check("mr_mosi",     32'(spi_mosi_ram),  32'h0);

        check("bus_rules",   32'(viol),          32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
